// File: rtl/seq_stream_mem.sv
// Strided sequential-read streamer: walks base + i*stride for length elements,
// issues credit-limited memory reads and delivers responses through a small FIFO.
module seq_stream_mem #(
   parameter int ADDR_WIDTH = 64,
   parameter int CNTR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [CNTR_WIDTH-1:0] cmd_length,
   input  logic [ADDR_WIDTH-1:0] cmd_stride,
   output logic                  mem_read,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ready,
   input  logic                  mem_resp,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  valid_o,
   output logic [DATA_WIDTH:0]   data_o,
   input  logic                  ready_i,
   output logic                  done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, stride_reg;
   logic [CNTR_WIDTH-1:0] length_reg, issue_cnt_reg, resp_cnt_reg, pop_cnt_reg;
   logic [CNT_W-1:0]      outstanding_reg, fifo_count_reg;
   logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
   logic                  done_reg;

   logic                  accept_cmd, issue_fire, resp_fire, pop, credit_ok, resp_last;
   logic [CNT_W:0]        credit_used;

   // Requests in flight plus buffered entries may never exceed the FIFO size.
   // Neither term can grow without an accepted request, so mem_read holds while stalled.
   always_comb begin
      credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};
      credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);
      state_next  = state_reg;
      cmd_ready   = 1'b0;
      mem_read    = 1'b0;
      case (state_reg)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_next = (cmd_length != '0) ? ISSUE : DRAIN;
         end
         ISSUE: begin
            mem_read = credit_ok;
            if (credit_ok && mem_ready && issue_cnt_reg == length_reg - CNTR_WIDTH'(1))
               state_next = DRAIN;
         end
         DRAIN: begin
            if (pop_cnt_reg == length_reg)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept_cmd = cmd_ready && cmd_valid;
   assign issue_fire = mem_read && mem_ready;
   assign resp_fire  = mem_resp && (outstanding_reg != '0);
   assign resp_last  = (resp_cnt_reg == length_reg - CNTR_WIDTH'(1));
   assign valid_o    = (fifo_count_reg != '0);
   assign pop        = valid_o && ready_i;
   assign data_o     = valid_o ? fifo_mem[rd_ptr_reg] : '0;
   assign mem_addr   = addr_reg;
   assign done       = done_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         addr_reg        <= '0;
         stride_reg      <= '0;
         length_reg      <= '0;
         issue_cnt_reg   <= '0;
         resp_cnt_reg    <= '0;
         pop_cnt_reg     <= '0;
         outstanding_reg <= '0;
         fifo_count_reg  <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         done_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         // Registered pulse lands in the same cycle cmd_ready comes back.
         done_reg  <= (state_reg == DRAIN) && (state_next == IDLE);

         if (accept_cmd) begin
            addr_reg      <= cmd_base;
            stride_reg    <= cmd_stride;
            length_reg    <= cmd_length;
            issue_cnt_reg <= '0;
            resp_cnt_reg  <= '0;
            pop_cnt_reg   <= '0;
         end else begin
            if (issue_fire) begin
               addr_reg      <= addr_reg + stride_reg;
               issue_cnt_reg <= issue_cnt_reg + CNTR_WIDTH'(1);
            end
            if (resp_fire)
               resp_cnt_reg <= resp_cnt_reg + CNTR_WIDTH'(1);
            if (pop)
               pop_cnt_reg <= pop_cnt_reg + CNTR_WIDTH'(1);
         end

         case ({issue_fire, resp_fire})
            2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
            2'b01:   outstanding_reg <= outstanding_reg - CNT_W'(1);
            default: outstanding_reg <= outstanding_reg;
         endcase

         case ({resp_fire, pop})
            2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
            2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
            default: fifo_count_reg <= fifo_count_reg;
         endcase

         if (resp_fire)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
   end

   // Storage carries no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (!rst && resp_fire)
         fifo_mem[wr_ptr_reg] <= {mem_rdata, resp_last};
   end

endmodule

// File: tb/tb_seq_stream_mem.sv
// Directed bench for seq_stream_mem: memory model with fixed response latency,
// consumer model, and per-scenario inline checks.
module tb_seq_stream_mem;

   localparam int AW = 64;
   localparam int CW = 32;
   localparam int DW = 64;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_base = '0;
   logic [CW-1:0] cmd_length = '0;
   logic [AW-1:0] cmd_stride = '0;
   logic          mem_read;
   logic [AW-1:0] mem_addr;
   logic          mem_ready = 1'b0;
   logic          mem_resp = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          valid_o;
   logic [DW:0]   data_o;
   logic          ready_i = 1'b0;
   logic          done;

   always #5 clk = ~clk;

   seq_stream_mem #(.ADDR_WIDTH(AW), .CNTR_WIDTH(CW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base(cmd_base), .cmd_length(cmd_length), .cmd_stride(cmd_stride),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i), .done(done)
   );

   int checks = 0;
   int errors = 0;

   bit consumer_ready = 1'b1;
   bit consumer_random = 1'b0;
   bit mem_random = 1'b0;

   logic [AW-1:0] addr_log[$];
   logic [DW:0]   out_log[$];

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } resp_t;
   resp_t resp_q[$];
   resp_t new_resp;

   int            cyc = 0;
   int            done_cnt = 0;
   int            stab_viol = 0;
   bit            prev_stall = 1'b0;
   logic [AW-1:0] prev_addr = '0;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {a[31:0] ^ 32'hDEADBEEF, a[31:0]};
   endfunction

   // Memory answers two cycles after each accepted request; consumer pops per ready_i.
   always @(negedge clk) begin
      cyc++;
      mem_ready = mem_random ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_i   = consumer_random ? ($urandom_range(0, 3) != 0) : consumer_ready;
      if (rst) begin
         resp_q.delete();
         mem_resp   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
            mem_resp  = 1'b1;
            mem_rdata = resp_q[0].data;
            void'(resp_q.pop_front());
         end else begin
            mem_resp = 1'b0;
         end
         if (prev_stall && (!mem_read || mem_addr !== prev_addr))
            stab_viol++;
         if (mem_read && mem_ready) begin
            addr_log.push_back(mem_addr);
            new_resp.due  = cyc + 2;
            new_resp.data = mem_word(mem_addr);
            resp_q.push_back(new_resp);
         end
         if (valid_o && ready_i)
            out_log.push_back(data_o);
         if (done)
            done_cnt++;
         prev_stall = mem_read && !mem_ready;
         prev_addr  = mem_addr;
      end
   end

   task automatic clear_logs();
      addr_log.delete();
      out_log.delete();
      done_cnt  = 0;
      stab_viol = 0;
   endtask

   task automatic send_cmd(input logic [AW-1:0] base, input logic [CW-1:0] len,
                           input logic [AW-1:0] stride);
      bit seen;
      @(posedge clk); #1;
      cmd_valid  = 1'b1;
      cmd_base   = base;
      cmd_length = len;
      cmd_stride = stride;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk); #1;
         seen = cmd_ready;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      $display("cmd base=%h length=%0d stride=%h", base, len, stride);
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk); #1;
         seen = done;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_done_timeout: done=%0b required 1", name, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready); end
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %0b required 0", mem_read); end
      checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %0b required 0", valid_o); end
      checks++; if (data_o !== 65'h0) begin errors++; $display("FAIL reset_data_o: got %h required 0", data_o); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b required 0", done); end
      @(posedge clk); #1;
      rst = 1'b0;
      $display("reset checked");
   endtask

   task automatic test_basic();
      logic [AW-1:0] exp_a [4];
      exp_a = '{64'h1000, 64'h1008, 64'h1010, 64'h1018};
      clear_logs();
      consumer_ready = 1'b1;
      send_cmd(64'h1000, 32'd4, 64'h8);
      wait_done("basic");
      repeat (3) @(negedge clk);
      #1;
      checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL basic_addr_count: got %0d required 4", addr_log.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL basic_addr[%0d]: got %h required %h", i, addr_log[i], exp_a[i]); end
      end
      checks++; if (out_log.size() != 4) begin errors++; $display("FAIL basic_out_count: got %0d required 4", out_log.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_log[i] !== {mem_word(exp_a[i]), i == 3}) begin
            errors++; $display("FAIL basic_out[%0d]: got %h required %h", i, out_log[i], {mem_word(exp_a[i]), i == 3});
         end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt); end
   endtask

   task automatic test_zero_length();
      clear_logs();
      send_cmd(64'h7000, 32'd0, 64'h8);
      @(negedge clk); #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL zero_cmd_ready_busy: got %0b required 0", cmd_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %0b required 0", done); end
      @(negedge clk); #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse: got %0b required 1", done); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_cmd_ready_back: got %0b required 1", cmd_ready); end
      @(negedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %0b required 0", done); end
      checks++; if (addr_log.size() != 0) begin errors++; $display("FAIL zero_no_reads: got %0d required 0", addr_log.size()); end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] exp_a [8];
      exp_a = '{64'h2000, 64'h2010, 64'h2020, 64'h2030, 64'h2040, 64'h2050, 64'h2060, 64'h2070};
      clear_logs();
      consumer_ready = 1'b0;
      send_cmd(64'h2000, 32'd8, 64'h10);
      repeat (20) @(negedge clk);
      #1;
      checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL bp_stalled_issue: got %0d required 4", addr_log.size()); end
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL bp_mem_read_low: got %0b required 0", mem_read); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %0b required 1", valid_o); end
      checks++; if (data_o !== {mem_word(64'h2000), 1'b0}) begin errors++; $display("FAIL bp_head_stable: got %h required %h", data_o, {mem_word(64'h2000), 1'b0}); end
      @(posedge clk); #1;
      consumer_ready = 1'b1;
      wait_done("bp");
      @(negedge clk); #1;
      checks++; if (addr_log.size() != 8) begin errors++; $display("FAIL bp_addr_count: got %0d required 8", addr_log.size()); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_log[i] !== {mem_word(exp_a[i]), i == 7}) begin
            errors++; $display("FAIL bp_out[%0d]: got %h required %h", i, out_log[i], {mem_word(exp_a[i]), i == 7});
         end
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_a [3];
      exp_a = '{64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8};
      clear_logs();
      consumer_ready = 1'b1;
      send_cmd(64'hFFFF_FFFF_FFFF_FFF8, 32'd3, 64'h8);
      wait_done("wrap");
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h required %h", i, addr_log[i], exp_a[i]); end
      end
      checks++;
      if (out_log[2] !== {mem_word(64'h8), 1'b1}) begin errors++; $display("FAIL wrap_last: got %h required %h", out_log[2], {mem_word(64'h8), 1'b1}); end
   endtask

   task automatic test_random_ready();
      logic [AW-1:0] exp_a [10];
      exp_a = '{64'h3000, 64'h3004, 64'h3008, 64'h300C, 64'h3010,
                64'h3014, 64'h3018, 64'h301C, 64'h3020, 64'h3024};
      clear_logs();
      mem_random = 1'b1;
      consumer_random = 1'b1;
      send_cmd(64'h3000, 32'd10, 64'h4);
      wait_done("rand");
      @(negedge clk); #1;
      mem_random = 1'b0;
      consumer_random = 1'b0;
      checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_addr_stability: got %0d violations required 0", stab_viol); end
      checks++; if (addr_log.size() != 10) begin errors++; $display("FAIL rand_addr_count: got %0d required 10", addr_log.size()); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL rand_addr[%0d]: got %h required %h", i, addr_log[i], exp_a[i]); end
         checks++;
         if (out_log[i] !== {mem_word(exp_a[i]), i == 9}) begin
            errors++; $display("FAIL rand_out[%0d]: got %h required %h", i, out_log[i], {mem_word(exp_a[i]), i == 9});
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      clear_logs();
      consumer_ready = 1'b1;
      send_cmd(64'h4000, 32'd6, 64'h40);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk); #1;
         seen = (out_log.size() >= 2);
      end
      checks++; if (!seen) begin errors++; $display("FAIL mid_two_outputs_timeout: got %0d required 2", out_log.size()); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid_o: got %0b required 0", valid_o); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready: got %0b required 1", cmd_ready); end
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL mid_mem_read: got %0b required 0", mem_read); end
      rst = 1'b0;
      clear_logs();
      send_cmd(64'h5000, 32'd2, 64'h20);
      wait_done("mid");
      @(negedge clk); #1;
      checks++; if (addr_log.size() != 2) begin errors++; $display("FAIL mid_new_addr_count: got %0d required 2", addr_log.size()); end
      checks++; if (out_log.size() != 2) begin errors++; $display("FAIL mid_new_out_count: got %0d required 2", out_log.size()); end
      checks++; if (out_log[0] !== {mem_word(64'h5000), 1'b0}) begin errors++; $display("FAIL mid_new_out0: got %h required %h", out_log[0], {mem_word(64'h5000), 1'b0}); end
      checks++; if (out_log[1] !== {mem_word(64'h5020), 1'b1}) begin errors++; $display("FAIL mid_new_out1: got %h required %h", out_log[1], {mem_word(64'h5020), 1'b1}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_length();
      test_backpressure();
      test_wrap();
      test_random_ready();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
